// File: rtl/button_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ui_ctrl_pkg
// Purpose : shared arbiter types and the round-robin pick helper
// Rev     : 1.0  initial release
// ============================================================================
package ui_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   localparam int MAX_BTN  = 16;
   localparam int MAX_ID_W = 4;

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] idx;
   } rr_pick_t;

   // First set bit of pend scanning ptr, ptr+1, ... wrapping at n.
   // Walks downward so the last hit written is the closest one to ptr.
   function automatic rr_pick_t rr_pick(input logic [MAX_BTN-1:0]  pend,
                                        input logic [MAX_ID_W-1:0] ptr,
                                        input int                  n);
      rr_pick_t r;
      int       idx;
      r = '0;
      for (int k = MAX_BTN - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= n) idx = idx - n;
         if (k < n && pend[idx[MAX_ID_W-1:0]]) begin
            r.found = 1'b1;
            r.idx   = idx[MAX_ID_W-1:0];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : button_cmd_scheduler_if
// Purpose : valid/ready command handshake towards the shared consumer
// Rev     : 1.0  initial release
// ============================================================================
interface button_cmd_scheduler_if #(
   parameter int N_BTN = 4
);
   localparam int ID_W = $clog2(N_BTN);

   logic            cmd_valid;
   logic            cmd_ready;
   logic [ID_W-1:0] cmd_id;

   modport master (output cmd_valid, output cmd_id, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/button_cmd_scheduler_level_to_pulse.sv
`default_nettype none
// ============================================================================
// Module  : level_to_pulse
// Purpose : one-cycle registered pulse on each sampled low-to-high level change
// Rev     : 1.0  initial release
// ============================================================================
module level_to_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);
   logic level_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level & ~level_q;
      end
   end
endmodule
`default_nettype wire

// File: rtl/button_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : button_cmd_scheduler
// Purpose : button presses/auto-repeats queued and granted round-robin
// Rev     : 1.0  initial release
// ============================================================================
module button_cmd_scheduler
   import ui_ctrl_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int REPEAT_EN  = 1,
   parameter int REPEAT_DLY = 50_000_000,
   parameter int REPEAT_PER = 10_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_BTN-1:0]        btn_level,
   button_cmd_scheduler_if.master  cmd,
   output logic [N_BTN-1:0]        pending,
   output logic                    overrun
);
   localparam int ID_W    = $clog2(N_BTN);
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CNT_W   = $clog2(REP_MAX + 1);

   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] rep;
   logic [N_BTN-1:0] req;
   logic [N_BTN-1:0] grant_clr;
   logic [ID_W-1:0]  rr_ptr;
   arb_state_t       state;
   rr_pick_t         pick;

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_btn
         logic [CNT_W-1:0] rep_cnt;

         level_to_pulse u_l2p (
            .clk   (clk),
            .reset (reset),
            .level (btn_level[i]),
            .pulse (press[i])
         );

         // Down-counter: 1 marks the firing cycle, 0 means idle.
         always_ff @(posedge clk) begin
            if (reset)                        rep_cnt <= '0;
            else if (press[i])                rep_cnt <= CNT_W'(REPEAT_DLY);
            else if (!btn_level[i])           rep_cnt <= '0;
            else if (rep_cnt == CNT_W'(1))    rep_cnt <= CNT_W'(REPEAT_PER);
            else if (rep_cnt != '0)           rep_cnt <= rep_cnt - CNT_W'(1);
         end

         assign rep[i] = (REPEAT_EN != 0) && btn_level[i] && (rep_cnt == CNT_W'(1));
      end
   endgenerate

   assign req = press | rep;

   always_comb begin
      pick      = rr_pick(MAX_BTN'(pending), MAX_ID_W'(rr_ptr), N_BTN);
      grant_clr = '0;
      if (state == IDLE && pick.found) grant_clr = N_BTN'(1) << pick.idx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_id    <= '0;
         rr_ptr        <= '0;
         pending       <= '0;
         overrun       <= 1'b0;
      end else begin
         // A new request on the bit being granted re-queues it instead of dropping.
         overrun <= |(req & pending & ~grant_clr);
         pending <= (pending & ~grant_clr) | req;
         case (state)
            IDLE: begin
               if (pick.found) begin
                  cmd.cmd_valid <= 1'b1;
                  cmd.cmd_id    <= ID_W'(pick.idx);
                  state         <= OFFER;
               end
            end
            OFFER: begin
               if (cmd.cmd_ready) begin
                  cmd.cmd_valid <= 1'b0;
                  rr_ptr        <= (cmd.cmd_id == ID_W'(N_BTN - 1)) ? '0
                                                                     : cmd.cmd_id + ID_W'(1);
                  state         <= IDLE;
               end
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_button_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_cmd_scheduler
// Purpose : directed scenarios plus random levels against a cycle-age reference
// Rev     : 1.0  initial release
// ============================================================================
module tb_button_cmd_scheduler;
   localparam int N   = 4;
   localparam int DLY = 8;
   localparam int PER = 4;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic [N-1:0] btn_level = '0;
   logic [N-1:0] pending;
   logic         overrun;

   button_cmd_scheduler_if #(.N_BTN(N)) cmd_if ();

   button_cmd_scheduler #(
      .N_BTN(N), .REPEAT_EN(1), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_level (btn_level),
      .cmd       (cmd_if),
      .pending   (pending),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int ovr_seen = 0;
   int del_id[$];
   int del_cyc[$];

   // Reference: age = cycles since the press cycle, -1 when not held.
   logic [N-1:0] m_prev  = '0;
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_pend  = '0;
   logic         m_valid = 1'b0;
   logic         m_ovr   = 1'b0;
   int           m_id    = 0;
   int           m_rr    = 0;
   int           m_age [N] = '{default: -1};

   always @(posedge clk) begin : ref_model
      logic [N-1:0] req;
      logic [N-1:0] clr;
      logic [N-1:0] sh;
      int           g;
      bit           found;
      if (reset) begin
         m_prev <= '0; m_press <= '0; m_pend <= '0;
         m_valid <= 1'b0; m_ovr <= 1'b0; m_id <= 0; m_rr <= 0;
         for (int i = 0; i < N; i++) m_age[i] <= -1;
      end else begin
         req = '0; clr = '0; found = 0; g = 0;
         for (int i = 0; i < N; i++) begin
            if (m_press[i] || (btn_level[i] && m_age[i] >= DLY && (m_age[i] - DLY) % PER == 0))
               req[i] = 1'b1;
            if (btn_level[i] && !m_prev[i])                              m_age[i] <= 0;
            else if (m_age[i] >= 0 && (m_age[i] == 0 || btn_level[i]))  m_age[i] <= m_age[i] + 1;
            else                                                         m_age[i] <= -1;
         end
         m_press <= btn_level & ~m_prev;
         m_prev  <= btn_level;
         if (!m_valid) begin
            for (int k = 0; k < N; k++) begin
               sh = m_pend >> ((m_rr + k) % N);
               if (!found && sh[0]) begin found = 1; g = (m_rr + k) % N; end
            end
            if (found) begin
               clr = N'(1) << g;
               m_valid <= 1'b1;
               m_id    <= g;
            end
         end else if (cmd_if.cmd_ready) begin
            m_valid <= 1'b0;
            m_rr    <= (m_id + 1) % N;
         end
         m_ovr  <= |(req & m_pend & ~clr);
         m_pend <= (m_pend & ~clr) | req;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      if (cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_ready === 1'b1) begin
         del_id.push_back(int'(cmd_if.cmd_id));
         del_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (overrun === 1'b1) ovr_seen++;
      chk("model_valid",   32'(cmd_if.cmd_valid), 32'(m_valid));
      chk("model_id",      32'(cmd_if.cmd_id),    32'(m_id));
      chk("model_pending", 32'(pending),          32'(m_pend));
      chk("model_overrun", 32'(overrun),          32'(m_ovr));
   endtask

   initial begin
      int n0;
      cmd_if.cmd_ready = 1'b0;

      // 1: reset values, single press latency
      reset = 1'b1; tick(); tick();
      chk("rst_valid",   32'(cmd_if.cmd_valid), 32'd0);
      chk("rst_id",      32'(cmd_if.cmd_id),    32'd0);
      chk("rst_pending", 32'(pending),          32'd0);
      chk("rst_overrun", 32'(overrun),          32'd0);
      reset = 1'b0; cmd_if.cmd_ready = 1'b1; btn_level = 4'b0001;
      tick(); chk("t1_t0_valid", 32'(cmd_if.cmd_valid), 32'd0);
      tick(); chk("t1_t1_pend",  32'(pending), 32'b0001);
              chk("t1_t1_valid", 32'(cmd_if.cmd_valid), 32'd0);
      tick(); chk("t1_t2_valid", 32'(cmd_if.cmd_valid), 32'd1);
              chk("t1_t2_id",    32'(cmd_if.cmd_id), 32'd0);
              chk("t1_t2_pend",  32'(pending), 32'd0);
      btn_level = '0;
      tick(); chk("t1_t3_valid", 32'(cmd_if.cmd_valid), 32'd0);
              chk("t1_t3_pend",  32'(pending), 32'd0);
      tick(); tick();

      // 2: simultaneous btn1/btn3 from rr_ptr=0
      reset = 1'b1; tick(); reset = 1'b0;
      btn_level = 4'b1010;
      tick(); tick(); chk("t2_pend", 32'(pending), 32'b1010);
      tick(); btn_level = '0;
      chk("t2_g1_valid", 32'(cmd_if.cmd_valid), 32'd1);
      chk("t2_g1_id",    32'(cmd_if.cmd_id), 32'd1);
      chk("t2_g1_pend",  32'(pending), 32'b1000);
      tick(); chk("t2_gap_valid", 32'(cmd_if.cmd_valid), 32'd0);
      tick(); chk("t2_g2_valid", 32'(cmd_if.cmd_valid), 32'd1);
              chk("t2_g2_id",    32'(cmd_if.cmd_id), 32'd3);
      tick(); chk("t2_end_valid", 32'(cmd_if.cmd_valid), 32'd0);
              chk("t2_end_pend",  32'(pending), 32'd0);
      tick();

      // 3: back-pressure on id=2 for 5 cycles
      cmd_if.cmd_ready = 1'b0; btn_level = 4'b0100;
      tick(); tick(); tick(); btn_level = '0;
      for (int k = 1; k <= 5; k++) begin
         chk("t3_hold_valid", 32'(cmd_if.cmd_valid), 32'd1);
         chk("t3_hold_id",    32'(cmd_if.cmd_id), 32'd2);
         tick();
      end
      chk("t3_c6_valid", 32'(cmd_if.cmd_valid), 32'd1);
      chk("t3_c6_id",    32'(cmd_if.cmd_id), 32'd2);
      cmd_if.cmd_ready = 1'b1;
      tick(); chk("t3_acc_valid", 32'(cmd_if.cmd_valid), 32'd0);
      tick();

      // 4: overrun while pending[0] waits behind an offered id=1
      cmd_if.cmd_ready = 1'b0; del_id.delete(); del_cyc.delete();
      btn_level = 4'b0010; tick(); tick(); btn_level = '0; tick();
      chk("t4_offer_id", 32'(cmd_if.cmd_id), 32'd1);
      ovr_seen = 0;
      btn_level = 4'b0001; tick(); btn_level = '0; tick();
      chk("t4_pend0", 32'(pending), 32'b0001);
      tick(); btn_level = 4'b0001; tick(); btn_level = '0; tick();
      chk("t4_overrun", 32'(overrun), 32'd1);
      tick();
      cmd_if.cmd_ready = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      n0 = 0;
      foreach (del_id[j]) if (del_id[j] == 0) n0++;
      chk("t4_ovr_pulses", 32'(ovr_seen), 32'd1);
      chk("t4_id0_cmds",   32'(n0), 32'd1);
      chk("t4_total_cmds", 32'(del_id.size()), 32'd2);

      // 5: auto-repeat on held btn2
      del_id.delete(); del_cyc.delete();
      btn_level = 4'b0100;
      for (int k = 0; k < 20; k++) tick();
      btn_level = '0;
      for (int k = 0; k < 6; k++) tick();
      chk("t5_count", 32'(del_id.size()), 32'd4);
      if (del_id.size() == 4) begin
         chk("t5_gap1", 32'(del_cyc[1] - del_cyc[0]), 32'd8);
         chk("t5_gap2", 32'(del_cyc[2] - del_cyc[1]), 32'd4);
         chk("t5_gap3", 32'(del_cyc[3] - del_cyc[2]), 32'd4);
         foreach (del_id[j]) chk("t5_id", 32'(del_id[j]), 32'd2);
      end

      // 6: reset in OFFER with pending=1010
      cmd_if.cmd_ready = 1'b0;
      btn_level = 4'b0001; tick(); tick(); btn_level = '0; tick();
      btn_level = 4'b1010; tick(); tick(); btn_level = '0; tick();
      chk("t6_pre_pend",  32'(pending), 32'b1010);
      chk("t6_pre_valid", 32'(cmd_if.cmd_valid), 32'd1);
      reset = 1'b1; tick();
      chk("t6_valid",   32'(cmd_if.cmd_valid), 32'd0);
      chk("t6_pend",    32'(pending), 32'd0);
      chk("t6_overrun", 32'(overrun), 32'd0);
      reset = 1'b0; cmd_if.cmd_ready = 1'b1;
      btn_level = 4'b1010; tick(); tick(); btn_level = '0; tick();
      chk("t6_rr0_id", 32'(cmd_if.cmd_id), 32'd1);
      for (int k = 0; k < 6; k++) tick();

      // Random levels, back-pressure and occasional reset against the reference
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 11) == 0) btn_level[i] = ~btn_level[i];
         cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
